layer1_fm_ctrl: RTL and testbench

LAYER1_FM_CTRL -- requirements
Module: layer1_fm_ctrl

---
 rtl/layer1_fm_ctrl_if.sv | 31 +++
 rtl/layer1_fm_ctrl.sv | 122 ++++++++++++
 tb/tb_layer1_fm_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer1_fm_ctrl_if.sv
// Handshake and status bundle between the pool stage, the 16 feature-map buffers
// and the downstream layer. The slave modport is the controller's view.
interface layer1_fm_ctrl_if;
    logic       wr_req;
    logic       wr_grant;
    logic       pre_vsync;
    logic       pre_href;
    logic       fm_wea;
    logic       fm_vsync;
    logic       fm_href;
    logic       save_fm_acmp;
    logic       rd_req;
    logic       start_output;
    logic       end_output;
    logic       fm_full;
    logic       layer_done;
    logic [2:0] err_flags;
    logic [7:0] frame_cnt;

    modport slave (
        input  wr_req, pre_vsync, pre_href, save_fm_acmp, rd_req, end_output,
        output wr_grant, fm_wea, fm_vsync, fm_href, start_output, fm_full,
               layer_done, err_flags, frame_cnt
    );

    modport master (
        output wr_req, pre_vsync, pre_href, save_fm_acmp, rd_req, end_output,
        input  wr_grant, fm_wea, fm_vsync, fm_href, start_output, fm_full,
               layer_done, err_flags, frame_cnt
    );
endinterface

// File: rtl/layer1_fm_ctrl.sv
// Sequences one feature-map frame: write from pool stage, hold, read out to next layer.
// wr_grant/fm_href/fm_vsync are combinational; strobes/flags follow the state register.
// Upstream stalls on wr_req until IDLE; downstream is bounded by RD_TIMEOUT.
module layer1_fm_ctrl #(
    parameter int FM_WIDTH   = 4,
    parameter int FM_HEIGHT  = 4,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    layer1_fm_ctrl_if.slave  fm
);
    localparam int NPIX = FM_WIDTH * FM_HEIGHT;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int TW   = $clog2(RD_TIMEOUT + 1);
    localparam logic [PW-1:0] PIX_MAX  = PW'(NPIX);
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, FULL, READ, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pix_cnt, pix_cnt_nxt;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [2:0]    err_q, err_nxt;
    logic [7:0]    frame_q, frame_nxt;

    logic wr_grant, fm_wea, fm_vsync, fm_href, start_output, fm_full, layer_done;
    logic pix_room;

    assign pix_room = (pix_cnt != PIX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pix_cnt <= '0;
            tmo_cnt <= '0;
            err_q   <= '0;
            frame_q <= '0;
        end else begin
            state   <= state_nxt;
            pix_cnt <= pix_cnt_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            err_q   <= err_nxt;
            frame_q <= frame_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pix_cnt_nxt  = pix_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        err_nxt      = err_q;
        frame_nxt    = frame_q;
        wr_grant     = 1'b0;
        fm_wea       = 1'b0;
        fm_vsync     = 1'b0;
        fm_href      = 1'b0;
        start_output = 1'b0;
        fm_full      = 1'b0;
        layer_done   = 1'b0;
        case (state)
            IDLE: begin
                if (fm.wr_req) begin
                    wr_grant    = 1'b1;
                    pix_cnt_nxt = '0;
                    state_nxt   = WRITE;
                end
            end
            WRITE: begin
                fm_wea = 1'b1;
                // Once the frame is full, further pixels are dropped and flagged.
                if (pix_room) begin
                    fm_vsync = fm.pre_vsync;
                    fm_href  = fm.pre_href;
                    if (fm.pre_href) pix_cnt_nxt = pix_cnt + 1'b1;
                end else if (fm.pre_href) begin
                    err_nxt[0] = 1'b1;
                end
                if (fm.save_fm_acmp) begin
                    state_nxt = FULL;
                    if (pix_room) err_nxt[1] = 1'b1;
                end
            end
            FULL: begin
                fm_full = 1'b1;
                if (fm.rd_req) begin
                    tmo_cnt_nxt = '0;
                    state_nxt   = READ;
                end
            end
            READ: begin
                fm_full      = 1'b1;
                start_output = (tmo_cnt == '0);
                if (fm.end_output) begin
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt[2] = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            DONE: begin
                layer_done = 1'b1;
                frame_nxt  = frame_q + 8'd1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The grant is the only input-driven output in IDLE, so it alone needs masking in reset.
    assign fm.wr_grant     = wr_grant & rst_n;
    assign fm.fm_wea       = fm_wea;
    assign fm.fm_vsync     = fm_vsync;
    assign fm.fm_href      = fm_href;
    assign fm.start_output = start_output;
    assign fm.fm_full      = fm_full;
    assign fm.layer_done   = layer_done;
    assign fm.err_flags    = err_q;
    assign fm.frame_cnt    = frame_q;
endmodule

// File: tb/tb_layer1_fm_ctrl.sv
// Directed frame scenarios plus randomized frames, checked against a transaction-level model.
module tb_layer1_fm_ctrl;
    localparam int NPIX = 16;
    localparam int TMO  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    layer1_fm_ctrl_if bus ();

    layer1_fm_ctrl #(.FM_WIDTH(4), .FM_HEIGHT(4), .RD_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fm    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n_grant = 0, n_href = 0, n_start = 0, n_done = 0;
    logic [2:0] err_exp  = 3'b000;
    logic [7:0] fcnt_exp = 8'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_grant)     n_grant++;
            if (bus.fm_href)      n_href++;
            if (bus.start_output) n_start++;
            if (bus.layer_done)   n_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.pre_href = 1'b0;
        bus.pre_vsync = 1'b0; bus.save_fm_acmp = 1'b0; bus.end_output = 1'b0;
    endtask

    // Asserts reset with every input high; all outputs must drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.pre_href = 1'b1;
        bus.pre_vsync = 1'b1; bus.save_fm_acmp = 1'b1; bus.end_output = 1'b1;
        #1;
        chk1("rst_wr_grant", bus.wr_grant, 1'b0);
        chk1("rst_fm_wea", bus.fm_wea, 1'b0);
        chk1("rst_fm_vsync", bus.fm_vsync, 1'b0);
        chk1("rst_fm_href", bus.fm_href, 1'b0);
        chk1("rst_start", bus.start_output, 1'b0);
        chk1("rst_full", bus.fm_full, 1'b0);
        chk1("rst_done", bus.layer_done, 1'b0);
        chk3("rst_err", bus.err_flags, 3'b000);
        chk8("rst_frame_cnt", bus.frame_cnt, 8'd0);
        err_exp  = 3'b000;
        fcnt_exp = 8'd0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            bus.wr_req = 1'b0; bus.rd_req = 1'b1;
            bus.save_fm_acmp = 1'($urandom); bus.end_output = 1'($urandom);
            bus.pre_href = 1'($urandom);
            @(negedge clk);
            chk1("idle_no_grant", bus.wr_grant, 1'b0);
            chk1("idle_no_start", bus.start_output, 1'b0);
            chk1("idle_no_full", bus.fm_full, 1'b0);
            chk1("idle_no_wea", bus.fm_wea, 1'b0);
            chk1("idle_no_href", bus.fm_href, 1'b0);
            chk1("idle_no_done", bus.layer_done, 1'b0);
            tick();
        end
        clear_inputs();
    endtask

    // One frame: n_pix pixels, end_output in READ cycle rd_dly (>= TMO means never).
    task automatic run_frame(input int n_pix, input int rd_dly, input bit hold_wr, input bit rst_mid);
        int  pix = 0;
        int  sent = 0;
        int  g0 = n_grant, h0 = n_href, s0 = n_start, d0 = n_done;
        bit  timed_out = 1'b1;

        bus.wr_req = 1'b1; bus.rd_req = 1'($urandom);
        bus.save_fm_acmp = 1'($urandom); bus.end_output = 1'($urandom);
        bus.pre_href = 1'($urandom); bus.pre_vsync = 1'($urandom);
        @(negedge clk);
        chk1("idle_grant", bus.wr_grant, 1'b1);
        chk1("idle_wea", bus.fm_wea, 1'b0);
        chk1("idle_full", bus.fm_full, 1'b0);
        chk1("idle_href", bus.fm_href, 1'b0);
        tick();
        bus.save_fm_acmp = 1'b0;

        while (sent < n_pix) begin
            bus.pre_href   = ($urandom_range(0, 3) != 0);
            bus.pre_vsync  = 1'($urandom);
            bus.rd_req     = 1'($urandom);
            bus.end_output = 1'($urandom);
            bus.wr_req     = 1'($urandom);
            @(negedge clk);
            chk1("wr_wea", bus.fm_wea, 1'b1);
            chk1("wr_no_grant", bus.wr_grant, 1'b0);
            chk1("wr_no_full", bus.fm_full, 1'b0);
            chk1("wr_href", bus.fm_href, bus.pre_href && (pix < NPIX));
            chk1("wr_vsync", bus.fm_vsync, bus.pre_vsync && (pix < NPIX));
            if (bus.pre_href) begin
                if (pix < NPIX) pix++;
                else err_exp[0] = 1'b1;
                sent++;
            end
            tick();
        end

        bus.pre_href = 1'b0; bus.pre_vsync = 1'b0; bus.wr_req = 1'b0;
        bus.rd_req = 1'b0; bus.save_fm_acmp = 1'b1;
        @(negedge clk);
        chk1("save_wea", bus.fm_wea, 1'b1);
        if (pix != NPIX) err_exp[1] = 1'b1;
        tick();

        bus.wr_req = hold_wr;
        repeat ($urandom_range(0, 3)) begin
            bus.rd_req = 1'b0; bus.end_output = 1'($urandom); bus.save_fm_acmp = 1'($urandom);
            @(negedge clk);
            chk1("full_flag", bus.fm_full, 1'b1);
            chk1("full_wea", bus.fm_wea, 1'b0);
            chk1("full_no_grant", bus.wr_grant, 1'b0);
            chk1("full_no_start", bus.start_output, 1'b0);
            tick();
        end
        bus.rd_req = 1'b1; bus.save_fm_acmp = 1'b0;
        @(negedge clk);
        chk1("full_rd_flag", bus.fm_full, 1'b1);
        chk1("full_rd_no_grant", bus.wr_grant, 1'b0);
        tick();

        for (int i = 0; i < TMO; i++) begin
            bus.end_output   = (i == rd_dly);
            bus.rd_req       = 1'($urandom);
            bus.save_fm_acmp = 1'($urandom);
            if (rst_mid && i == 3) begin
                do_reset();
                return;
            end
            @(negedge clk);
            chk1("rd_start", bus.start_output, (i == 0));
            chk1("rd_full", bus.fm_full, 1'b1);
            chk1("rd_no_grant", bus.wr_grant, 1'b0);
            chk1("rd_no_done", bus.layer_done, 1'b0);
            chk1("rd_wea", bus.fm_wea, 1'b0);
            tick();
            if (i == rd_dly) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.end_output = 1'b0; bus.rd_req = 1'b0; bus.save_fm_acmp = 1'b0;

        if (timed_out) begin
            err_exp[2] = 1'b1;
        end else begin
            @(negedge clk);
            chk1("done_pulse", bus.layer_done, 1'b1);
            chk1("done_full", bus.fm_full, 1'b0);
            chk1("done_no_grant", bus.wr_grant, 1'b0);
            chk1("done_no_start", bus.start_output, 1'b0);
            tick();
            fcnt_exp = fcnt_exp + 8'd1;
        end

        chk3("frame_err", bus.err_flags, err_exp);
        chk8("frame_cnt", bus.frame_cnt, fcnt_exp);
        chki("grant_count", n_grant - g0, 1);
        chki("href_count", n_href - h0, (n_pix < NPIX) ? n_pix : NPIX);
        chki("start_count", n_start - s0, 1);
        chki("done_count", n_done - d0, timed_out ? 0 : 1);
    endtask

    initial begin
        clear_inputs();
        #2;
        do_reset();
        idle_cycles(4);

        run_frame(16, 5, 1'b0, 1'b0);
        chk3("clean_err", bus.err_flags, 3'b000);
        chk8("clean_cnt", bus.frame_cnt, 8'd1);

        run_frame(20, 2, 1'b0, 1'b0);
        chk3("overflow_err", bus.err_flags, 3'b001);
        chk8("overflow_cnt", bus.frame_cnt, 8'd2);

        do_reset();
        run_frame(10, 3, 1'b0, 1'b0);
        chk3("short_err", bus.err_flags, 3'b010);

        do_reset();
        run_frame(16, TMO, 1'b0, 1'b0);
        chk3("timeout_err", bus.err_flags, 3'b100);
        chk8("timeout_cnt", bus.frame_cnt, 8'd0);
        idle_cycles(2);

        do_reset();
        run_frame(16, 0, 1'b1, 1'b0);
        run_frame(16, 7, 1'b1, 1'b0);
        run_frame(16, 4, 1'b0, 1'b0);
        chk8("held_wr_cnt", bus.frame_cnt, 8'd3);

        run_frame(16, 5, 1'b0, 1'b1);
        run_frame(16, 1, 1'b0, 1'b0);
        chk8("post_rst_cnt", bus.frame_cnt, 8'd1);
        chk3("post_rst_err", bus.err_flags, 3'b000);

        repeat (300) begin
            int pix_n, dly;
            pix_n = $urandom_range(12, 19);
            dly   = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
            run_frame(pix_n, dly, 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
